// File: rtl/note_recorder.sv
`default_nettype none
// ============================================================================
// Module      : note_recorder
// Description : Records live note keys, octave flags and hold times into an
//               event buffer and replays them to the music stage. In IDLE and
//               RECORD the live keys pass through; in PLAY stored events drive
//               the outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module note_recorder #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_MS = 10,
    parameter int DEPTH   = 64,
    parameter int DUR_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rec_en,
    input  logic                     play_en,
    input  logic [6:0]               notes_in,
    input  logic                     higher_in,
    input  logic                     lower_in,
    output logic [6:0]               notes_out,
    output logic                     higher_out,
    output logic                     lower_out,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int C_TICK_CYC = CLK_HZ / 1000 * TICK_MS;
    localparam int C_TW       = (C_TICK_CYC > 1) ? $clog2(C_TICK_CYC) : 1;
    localparam int C_AW       = $clog2(DEPTH);
    localparam int C_CW       = C_AW + 1;
    localparam int C_EW       = 9 + DUR_W;
    localparam logic [DUR_W-1:0] C_DMAX     = '1;
    localparam logic [C_CW-1:0]  C_DEPTH    = C_CW'(DEPTH);
    localparam logic [C_TW-1:0]  C_TICK_END = C_TW'(C_TICK_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REC  = 2'b01,
        S_PLAY = 2'b10
    } state_t;

    state_t            r_state;
    logic [10:0]       r_sync1;
    logic [10:0]       r_sync2;
    logic              r_rec_prev;
    logic              r_play_prev;
    logic [C_TW-1:0]   r_tick_cnt;
    logic [C_CW-1:0]   r_count;
    logic              r_full;
    logic [8:0]        r_cur;
    logic [DUR_W-1:0]  r_dur;
    logic [C_AW-1:0]   r_rd;
    logic [8:0]        r_ent;
    logic [DUR_W-1:0]  r_rem;
    logic [C_EW-1:0]   r_mem [DEPTH];
    logic [C_EW-1:0]   r_rd_data;

    logic              w_rec_s;
    logic              w_play_s;
    logic [8:0]        w_tuple;
    logic              w_rec_rise;
    logic              w_rec_fall;
    logic              w_play_rise;
    logic              w_play_fall;
    logic              w_tick;
    logic              w_same;
    logic              w_extend;
    logic              w_replace;
    logic              w_we;
    logic              w_last;
    logic              w_count_hits_full;
    logic [C_AW-1:0]   w_raddr;
    logic [C_AW-1:0]   w_waddr;
    logic [C_EW-1:0]   w_wdata;

    // Synchronised copies: {rec_en, play_en, notes, higher, lower}
    assign w_rec_s     = r_sync2[10];
    assign w_play_s    = r_sync2[9];
    assign w_tuple     = r_sync2[8:0];
    assign w_rec_rise  = w_rec_s & ~r_rec_prev;
    assign w_rec_fall  = ~w_rec_s & r_rec_prev;
    assign w_play_rise = w_play_s & ~r_play_prev;
    assign w_play_fall = ~w_play_s & r_play_prev;

    assign w_tick    = (r_state != S_IDLE) && (r_tick_cnt == C_TICK_END);
    assign w_same    = (w_tuple == r_cur);
    assign w_extend  = w_same && (r_dur != C_DMAX);
    assign w_replace = !w_same && (r_dur == '0);

    // Playback prefetches the entry after the current one so it is ready at the next boundary
    assign w_raddr = (r_state == S_PLAY) ? (r_rd + C_AW'(1)) : '0;
    assign w_waddr = r_count[C_AW-1:0];
    assign w_wdata = {r_cur, r_dur};
    assign w_last  = (({1'b0, r_rd} + C_CW'(1)) == r_count);
    assign w_count_hits_full = ((r_count + C_CW'(1)) == C_DEPTH);

    assign state = r_state;
    assign count = r_count;
    assign full  = r_full;

    // Buffer write request: flush on record stop, or close the current event on a tick
    always_comb begin
        w_we = 1'b0;
        if (r_state == S_REC) begin
            if (w_rec_fall) begin
                w_we = (r_dur != '0) && (r_count < C_DEPTH);
            end else if (w_tick) begin
                w_we = !w_extend && !w_replace;
            end
        end
    end

    // Two-stage synchronisers and edge-detect history for all switch inputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_rec_prev  <= 1'b0;
            r_play_prev <= 1'b0;
        end else begin
            r_sync1     <= {rec_en, play_en, notes_in, higher_in, lower_in};
            r_sync2     <= r_sync1;
            r_rec_prev  <= w_rec_s;
            r_play_prev <= w_play_s;
        end
    end

    // Event buffer: one write and one registered read per cycle, write-first on collision
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_rd_data <= (w_we && (w_waddr == w_raddr)) ? w_wdata : r_mem[w_raddr];
    end

    // Record/playback controller with registered music-stage outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_cur      <= '0;
            r_dur      <= '0;
            r_rd       <= '0;
            r_ent      <= '0;
            r_rem      <= '0;
            notes_out  <= '0;
            higher_out <= 1'b0;
            lower_out  <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_tick) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + C_TW'(1);
            end

            if (r_state == S_PLAY) begin
                {notes_out, higher_out, lower_out} <= r_ent;
            end else begin
                {notes_out, higher_out, lower_out} <= w_tuple;
            end

            if (w_we) begin
                r_count <= r_count + C_CW'(1);
                if (w_count_hits_full) begin
                    r_full <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_rec_rise) begin
                        r_state    <= S_REC;
                        r_count    <= '0;
                        r_full     <= 1'b0;
                        r_cur      <= w_tuple;
                        r_dur      <= '0;
                        r_tick_cnt <= '0;
                    end else if (w_play_rise && (r_count != '0) && !w_rec_s) begin
                        r_state    <= S_PLAY;
                        r_rd       <= '0;
                        r_ent      <= r_rd_data[C_EW-1:DUR_W];
                        r_rem      <= r_rd_data[DUR_W-1:0];
                        r_tick_cnt <= '0;
                    end
                end
                S_REC: begin
                    if (w_rec_fall) begin
                        r_state    <= S_IDLE;
                        r_tick_cnt <= '0;
                    end else if (w_tick) begin
                        if (w_extend) begin
                            r_dur <= r_dur + DUR_W'(1);
                        end else if (w_replace) begin
                            r_cur <= w_tuple;
                        end else begin
                            r_cur <= w_tuple;
                            r_dur <= DUR_W'(1);
                            if (w_count_hits_full) begin
                                r_state    <= S_IDLE;
                                r_tick_cnt <= '0;
                            end
                        end
                    end
                end
                S_PLAY: begin
                    if (w_play_fall) begin
                        r_state    <= S_IDLE;
                        r_tick_cnt <= '0;
                    end else if (w_tick) begin
                        if (r_rem <= DUR_W'(1)) begin
                            if (w_last) begin
                                r_state    <= S_IDLE;
                                r_tick_cnt <= '0;
                            end else begin
                                r_rd  <= r_rd + C_AW'(1);
                                r_ent <= r_rd_data[C_EW-1:DUR_W];
                                r_rem <= r_rd_data[DUR_W-1:0];
                            end
                        end else begin
                            r_rem <= r_rem - DUR_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_note_recorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_recorder
// Description : Directed, self-checking bench for note_recorder. A small
//               instance (tick = 4 cycles, 4 entries) covers passthrough,
//               recording, playback, full, abort and reset; a 64-entry
//               instance covers the duration-saturation split.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_recorder;

    logic       clk;
    logic       reset;
    logic       rec_a, play_a, rec_b, play_b;
    logic [6:0] notes_in;
    logic       higher_in, lower_in;

    logic [6:0] notes_out_a, notes_out_b;
    logic       higher_out_a, lower_out_a, higher_out_b, lower_out_b;
    logic [1:0] state_a, state_b;
    logic [2:0] count_a;
    logic [6:0] count_b;
    logic       full_a, full_b;
    logic [8:0] out_a, out_b;

    assign out_a = {notes_out_a, higher_out_a, lower_out_a};
    assign out_b = {notes_out_b, higher_out_b, lower_out_b};

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [8:0] stim;
        logic [8:0] exp;
    } pt_vec_t;

    typedef struct packed {
        logic [8:0]  tup;
        logic [15:0] cycles;
    } seg_t;

    pt_vec_t pt_tab [0:4];
    seg_t    segs[$];

    note_recorder #(.CLK_HZ(4000), .TICK_MS(1), .DEPTH(4), .DUR_W(8)) dut_a (
        .clk(clk), .reset(reset), .rec_en(rec_a), .play_en(play_a),
        .notes_in(notes_in), .higher_in(higher_in), .lower_in(lower_in),
        .notes_out(notes_out_a), .higher_out(higher_out_a), .lower_out(lower_out_a),
        .state(state_a), .count(count_a), .full(full_a)
    );

    note_recorder #(.CLK_HZ(4000), .TICK_MS(1), .DEPTH(64), .DUR_W(8)) dut_b (
        .clk(clk), .reset(reset), .rec_en(rec_b), .play_en(play_b),
        .notes_in(notes_in), .higher_in(higher_in), .lower_in(lower_in),
        .notes_out(notes_out_b), .higher_out(higher_out_b), .lower_out(lower_out_b),
        .state(state_b), .count(count_b), .full(full_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_tup(input logic [8:0] t);
        {notes_in, higher_in, lower_in} = t;
    endtask

    // Starts a playback on the small instance and checks the queued segments
    task automatic run_play(input string tag, input logic [8:0] live, input int rec_at);
        int idx;
        idx = 0;
        set_tup(live);
        play_a = 1'b1;
        cyc(4);
        check({tag, " state play"}, int'(state_a), 2);
        foreach (segs[s]) begin
            for (int j = 0; j < int'(segs[s].cycles); j++) begin
                check($sformatf("%s seg%0d cyc%0d", tag, s, j), int'(out_a), int'(segs[s].tup));
                if (idx == rec_at) rec_a = 1'b1;
                idx++;
                cyc(1);
            end
        end
        check({tag, " end state"}, int'(state_a), 0);
        check({tag, " end passthrough"}, int'(out_a), int'(live));
    endtask

    initial begin
        int sol_cnt;

        pt_tab[0] = '{stim: 9'b0010000_10, exp: 9'b0010000_10};
        pt_tab[1] = '{stim: 9'b1010101_01, exp: 9'b1010101_01};
        pt_tab[2] = '{stim: 9'b0000000_11, exp: 9'b0000000_11};
        pt_tab[3] = '{stim: 9'b0000001_00, exp: 9'b0000001_00};
        pt_tab[4] = '{stim: 9'b1111111_00, exp: 9'b1111111_00};

        reset = 1'b0;
        rec_a = 1'b0; play_a = 1'b0; rec_b = 1'b0; play_b = 1'b0;
        set_tup(9'b0);

        // Reset values
        cyc(3);
        check("reset out", int'(out_a), 0);
        check("reset state", int'(state_a), 0);
        check("reset count", int'(count_a), 0);
        check("reset full", int'(full_a), 0);

        // Release and observe the 3-cycle passthrough latency
        reset = 1'b1;
        set_tup(9'b0100000_00);
        cyc(2);
        check("latency early", int'(notes_out_a), 0);
        cyc(1);
        check("latency 3clk", int'(notes_out_a), 7'b0100000);

        // Passthrough table in IDLE
        for (int i = 0; i < 5; i++) begin
            set_tup(pt_tab[i].stim);
            cyc(3);
            check($sformatf("passthrough vec%0d", i), int'(out_a), int'(pt_tab[i].exp));
        end

        // Play request with an empty buffer is ignored
        play_a = 1'b1;
        cyc(5);
        check("play empty ignored", int'(state_a), 0);
        play_a = 1'b0;
        cyc(4);

        // Record: do 3 ticks, re+higher 2 ticks, rest 1 tick
        rec_a = 1'b1;
        set_tup(9'b1000000_00);
        cyc(14);
        check("rec state", int'(state_a), 1);
        check("rec count0", int'(count_a), 0);
        set_tup(9'b0100000_10);
        cyc(8);
        check("rec count1", int'(count_a), 1);
        set_tup(9'b0000000_00);
        cyc(4);
        rec_a = 1'b0;
        cyc(5);
        check("rec stop state", int'(state_a), 0);
        check("rec stop count", int'(count_a), 3);
        check("rec stop full", int'(full_a), 0);

        // Playback of the three events; a rec_en rise mid-play must be ignored
        segs.delete();
        segs.push_back({9'b1000000_00, 16'd12});
        segs.push_back({9'b0100000_10, 16'd8});
        segs.push_back({9'b0000000_00, 16'd4});
        run_play("play3", 9'b0000001_01, 5);
        cyc(4);
        check("rec rise in play ignored", int'(state_a), 0);
        check("count kept after play", int'(count_a), 3);
        rec_a = 1'b0;
        play_a = 1'b0;
        cyc(4);

        // Fill a 4-entry buffer with 6 one-tick notes
        rec_a = 1'b1;
        set_tup(9'b1000000_00);
        cyc(6);
        set_tup(9'b0100000_00);
        cyc(4);
        set_tup(9'b0010000_00);
        cyc(4);
        set_tup(9'b0001000_00);
        cyc(4);
        set_tup(9'b0000100_00);
        cyc(4);
        check("fill count3", int'(count_a), 3);
        set_tup(9'b0000010_00);
        cyc(4);
        check("full count", int'(count_a), 4);
        check("full flag", int'(full_a), 1);
        check("full state", int'(state_a), 0);

        // Play request while rec_en is still high is ignored
        play_a = 1'b1;
        cyc(5);
        check("play with rec high", int'(state_a), 0);
        play_a = 1'b0;
        rec_a = 1'b0;
        cyc(4);
        check("full held", int'(full_a), 1);

        // Abort during the second event
        set_tup(9'b0000011_10);
        play_a = 1'b1;
        cyc(4);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("abort ev0 cyc%0d", j), int'(out_a), 9'b1000000_00);
            cyc(1);
        end
        check("abort ev1", int'(out_a), 9'b0100000_00);
        play_a = 1'b0;
        cyc(3);
        check("abort state", int'(state_a), 0);
        check("abort count", int'(count_a), 4);
        cyc(1);
        check("abort passthrough", int'(out_a), 9'b0000011_10);

        // Restart plays from entry 0 through all four entries
        segs.delete();
        segs.push_back({9'b1000000_00, 16'd4});
        segs.push_back({9'b0100000_00, 16'd4});
        segs.push_back({9'b0010000_00, 16'd4});
        segs.push_back({9'b0001000_00, 16'd4});
        run_play("replay", 9'b0000011_10, -1);
        play_a = 1'b0;
        cyc(4);

        // Large instance: sol held 300 ticks splits into 255 + 45
        rec_b = 1'b1;
        set_tup(9'b0000100_00);
        cyc(1202);
        rec_b = 1'b0;
        cyc(5);
        check("long count", int'(count_b), 2);
        check("long state", int'(state_b), 0);
        check("long full", int'(full_b), 0);
        set_tup(9'b0000001_01);
        play_b = 1'b1;
        cyc(4);
        check("long play state", int'(state_b), 2);
        sol_cnt = 0;
        for (int i = 0; i < 1250; i++) begin
            if (out_b == 9'b0000100_00) sol_cnt++;
            cyc(1);
        end
        check("long play cycles", sol_cnt, 1200);
        check("long play end state", int'(state_b), 0);
        check("long play passthrough", int'(out_b), 9'b0000001_01);
        play_b = 1'b0;
        cyc(4);

        // Asynchronous reset in the middle of playback
        play_a = 1'b1;
        cyc(8);
        check("pre-reset play", int'(state_a), 2);
        reset = 1'b0;
        #1;
        check("async reset out", int'(out_a), 0);
        check("async reset state", int'(state_a), 0);
        check("async reset count", int'(count_a), 0);
        check("async reset full", int'(full_a), 0);
        check("async reset count b", int'(count_b), 0);
        cyc(1);
        reset = 1'b1;
        cyc(6);
        check("post-reset play ignored", int'(state_a), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
